// File: rtl/exec_writeback_pkg.sv
// Shared definitions for the execute-stage writeback merger.
//   DATA_WIDTH / REG_SEL : default result and register-index widths
//   MULT_LATENCY         : cycles from a sampled multiply select to the
//                          multiplier's ready pulse; the multiplier instance
//                          uses the same constant
//   FIFO_DEPTH           : ALU collision buffer depth
//   wb_entry_t           : one pending register-file write {rd, data}
package exec_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int REG_SEL      = 5;
  localparam int MULT_LATENCY = 3;
  localparam int FIFO_DEPTH   = 2;

  typedef struct packed {
    logic [REG_SEL-1:0]    rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/exec_writeback_if.sv
// Bus bundle between the execute stage and the writeback merger.
//   ALU side      : alu_valid, alu_rd, alu_result
//   Multiply side : mult_select, mult_rd, mult_ready, mult_result
//   Writeback     : wb_valid, wb_rd, wb_data, wb_from_mult
//   Hazard/status : mult_pending, pending_rd, alu_stall, protocol_error
// master = execute/issue side, slave = exec_writeback.
interface exec_writeback_if #(
  parameter int DATA_WIDTH = exec_pkg::DATA_WIDTH,
  parameter int REG_SEL    = exec_pkg::REG_SEL
);

  logic                  alu_valid;
  logic [REG_SEL-1:0]    alu_rd;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  mult_select;
  logic [REG_SEL-1:0]    mult_rd;
  logic                  mult_ready;
  logic [DATA_WIDTH-1:0] mult_result;
  logic                  wb_valid;
  logic [REG_SEL-1:0]    wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_from_mult;
  logic                  mult_pending;
  logic [REG_SEL-1:0]    pending_rd;
  logic                  alu_stall;
  logic                  protocol_error;

  modport master (
    output alu_valid, alu_rd, alu_result,
    output mult_select, mult_rd, mult_ready, mult_result,
    input  wb_valid, wb_rd, wb_data, wb_from_mult,
    input  mult_pending, pending_rd, alu_stall, protocol_error
  );

  modport slave (
    input  alu_valid, alu_rd, alu_result,
    input  mult_select, mult_rd, mult_ready, mult_result,
    output wb_valid, wb_rd, wb_data, wb_from_mult,
    output mult_pending, pending_rd, alu_stall, protocol_error
  );

endinterface

// File: rtl/exec_writeback_fifo.sv
// wb_fifo: small synchronous FIFO holding deferred ALU writebacks.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push/push_data : enqueue; accepted when not full or when a pop frees
//                    a slot in the same cycle
//   pop          : dequeue the head (ignored when empty)
//   head         : current head entry
//   full, empty, count : occupancy status
module wb_fifo
  import exec_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  wb_entry_t                    push_data,
  input  logic                         pop,
  output wb_entry_t                    head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/exec_writeback.sv
// exec_writeback: merges multiplier and ALU results onto one register-file
// write port, tracks the single in-flight multiply tag for the hazard unit,
// and buffers ALU results that lose arbitration in a 2-entry FIFO.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : ALU/multiply inputs, registered writeback outputs,
//                  pending tag, ALU stall and sticky protocol_error
module exec_writeback #(
  parameter int DATA_WIDTH   = exec_pkg::DATA_WIDTH,
  parameter int REG_SEL      = exec_pkg::REG_SEL,
  parameter int MULT_LATENCY = exec_pkg::MULT_LATENCY
) (
  input  logic          clock,
  input  logic          reset,
  exec_writeback_if.slave bus
);

  import exec_pkg::*;

  localparam int CNT_W  = $clog2(MULT_LATENCY + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  logic                  pend_q;
  logic [REG_SEL-1:0]    prd_q;
  logic [CNT_W-1:0]      lat_cnt_q;
  logic                  err_q;

  logic [FCNT_W-1:0]     fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  wb_entry_t             fifo_head;

  logic                  mult_done;
  logic                  mult_win;
  logic                  mult_stray;
  logic                  mult_timeout;
  logic                  alu_bypass;
  logic                  alu_defer;
  logic                  alu_drop;
  wb_entry_t             alu_entry_p0;
  wb_entry_t             sel_entry_p0;
  logic                  sel_valid_p0;
  logic                  sel_mult_p0;
  logic                  wr_en_p0;

  logic                  wb_valid_p1;
  logic [REG_SEL-1:0]    wb_rd_p1;
  logic [DATA_WIDTH-1:0] wb_data_p1;
  logic                  wb_from_mult_p1;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (alu_entry_p0),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ---- p0: arbitration over the inputs sampled this cycle ----
  always_comb begin
    mult_done    = pend_q && (lat_cnt_q == CNT_W'(MULT_LATENCY));
    mult_win     = bus.mult_ready && mult_done;
    mult_stray   = bus.mult_ready && !mult_done;
    mult_timeout = mult_done && !bus.mult_ready;
    // Buffered ALU results drain before a new one may bypass, which keeps
    // ALU writes in program order.
    fifo_pop     = !mult_win && !fifo_empty;
    alu_bypass   = bus.alu_valid && !mult_win && fifo_empty;
    alu_defer    = bus.alu_valid && !alu_bypass;
    fifo_push    = alu_defer && (!fifo_full || fifo_pop);
    alu_drop     = alu_defer && fifo_full && !fifo_pop;
    alu_entry_p0 = '{rd: bus.alu_rd, data: bus.alu_result};

    sel_entry_p0 = '0;
    sel_valid_p0 = 1'b0;
    sel_mult_p0  = 1'b0;
    if (mult_win) begin
      sel_entry_p0 = '{rd: prd_q, data: bus.mult_result};
      sel_valid_p0 = 1'b1;
      sel_mult_p0  = 1'b1;
    end else if (!fifo_empty) begin
      sel_entry_p0 = fifo_head;
      sel_valid_p0 = 1'b1;
    end else if (alu_bypass) begin
      sel_entry_p0 = alu_entry_p0;
      sel_valid_p0 = 1'b1;
    end
    // x0 writes still consume their slot but never reach the register file.
    wr_en_p0 = sel_valid_p0 && (sel_entry_p0.rd != '0);
  end

  // ---- p1: registered write port ----
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid_p1     <= 1'b0;
      wb_rd_p1        <= '0;
      wb_data_p1      <= '0;
      wb_from_mult_p1 <= 1'b0;
    end else begin
      wb_valid_p1     <= wr_en_p0;
      wb_rd_p1        <= wr_en_p0 ? sel_entry_p0.rd : '0;
      wb_data_p1      <= wr_en_p0 ? sel_entry_p0.data : '0;
      wb_from_mult_p1 <= wr_en_p0 && sel_mult_p0;
    end
  end

  // Tag tracking: a select is only honoured while idle, matching the
  // multiplier, and the tag retires at latency either way (ready or not).
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q    <= 1'b0;
      prd_q     <= '0;
      lat_cnt_q <= '0;
    end else if (mult_win || mult_timeout) begin
      pend_q    <= 1'b0;
      prd_q     <= '0;
      lat_cnt_q <= '0;
    end else if (pend_q) begin
      lat_cnt_q <= lat_cnt_q + 1'b1;
    end else if (bus.mult_select) begin
      pend_q    <= 1'b1;
      prd_q     <= bus.mult_rd;
      lat_cnt_q <= CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else if (mult_stray || mult_timeout || alu_drop) err_q <= 1'b1;
  end

  assign bus.wb_valid       = wb_valid_p1;
  assign bus.wb_rd          = wb_rd_p1;
  assign bus.wb_data        = wb_data_p1;
  assign bus.wb_from_mult   = wb_from_mult_p1;
  assign bus.mult_pending   = pend_q;
  assign bus.pending_rd     = prd_q;
  assign bus.alu_stall      = (fifo_count == FCNT_W'(FIFO_DEPTH));
  assign bus.protocol_error = err_q;

endmodule

// File: tb/tb_exec_writeback.sv
// Bench for exec_writeback: a directed vector table with hand-derived
// expectations, followed by randomized traffic compared against a
// queue-based reference model.
module tb_exec_writeback;

  localparam int LAT = 3;

  logic clock;
  logic reset;

  exec_writeback_if bus ();

  exec_writeback dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rst;
    bit          av;
    logic [4:0]  ard;
    logic [31:0] ares;
    bit          ms;
    logic [4:0]  mrd;
    bit          mr;
    logic [31:0] mres;
    bit          ev;
    logic [4:0]  erd;
    logic [31:0] edat;
    bit          efm;
    bit          ep;
    logic [4:0]  eprd;
    bit          est;
    bit          eerr;
    int          ecnt;
  } vec_t;

  vec_t vq[$];

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // reference model state
  ent_t        q[$];
  bit          m_pend;
  int          m_age;
  logic [4:0]  m_prd;
  bit          m_err;
  bit          e_v;
  logic [4:0]  e_rd;
  logic [31:0] e_dat;
  bit          e_fm;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic row(input bit rst, input bit av, input int ard, input int ares,
                     input bit ms, input int mrd, input bit mr, input int mres,
                     input bit ev, input int erd, input int edat, input bit efm,
                     input bit ep, input int eprd, input bit est, input bit eerr,
                     input int ecnt);
    vec_t v;
    v.rst = rst; v.av = av; v.ard = ard[4:0]; v.ares = ares;
    v.ms = ms; v.mrd = mrd[4:0]; v.mr = mr; v.mres = mres;
    v.ev = ev; v.erd = erd[4:0]; v.edat = edat; v.efm = efm;
    v.ep = ep; v.eprd = eprd[4:0]; v.est = est; v.eerr = eerr; v.ecnt = ecnt;
    vq.push_back(v);
  endtask

  task automatic drive(input bit rst, input bit av, input logic [4:0] ard,
                       input logic [31:0] ares, input bit ms, input logic [4:0] mrd,
                       input bit mr, input logic [31:0] mres);
    reset           = rst;
    bus.alu_valid   = av;
    bus.alu_rd      = ard;
    bus.alu_result  = ares;
    bus.mult_select = ms;
    bus.mult_rd     = mrd;
    bus.mult_ready  = mr;
    bus.mult_result = mres;
    @(posedge clock);
    #1;
  endtask

  // Behavioural model: one write per cycle chosen by priority, deferred ALU
  // results kept in a bounded queue, multiply tag aged in whole cycles.
  task automatic model_step(input bit rst, input bit av, input logic [4:0] ard,
                            input logic [31:0] ares, input bit ms,
                            input logic [4:0] mrd, input bit mr,
                            input logic [31:0] mres);
    ent_t e;
    bit   have;
    bit   fm;
    bit   bypassed;
    bit   mwin;
    e_v = 0; e_rd = '0; e_dat = '0; e_fm = 0;
    if (rst) begin
      q.delete();
      m_pend = 0; m_age = 0; m_prd = '0; m_err = 0;
      return;
    end
    have = 0; fm = 0; bypassed = 0;
    e.rd = '0; e.data = '0;
    mwin = mr && m_pend && (m_age == LAT);
    if (mwin) begin
      e.rd = m_prd; e.data = mres; have = 1; fm = 1;
    end else if (q.size() > 0) begin
      e = q.pop_front(); have = 1;
    end else if (av) begin
      e.rd = ard; e.data = ares; have = 1; bypassed = 1;
    end
    if (av && !bypassed) begin
      if (q.size() < 2) begin
        ent_t n;
        n.rd = ard; n.data = ares;
        q.push_back(n);
      end else m_err = 1;
    end
    if (mr && !mwin) m_err = 1;
    if (m_pend && m_age == LAT) begin
      if (!mr) m_err = 1;
      m_pend = 0;
    end else if (m_pend) begin
      m_age++;
    end else if (ms) begin
      m_pend = 1; m_age = 1; m_prd = mrd;
    end
    if (have && e.rd != 0) begin
      e_v = 1; e_rd = e.rd; e_dat = e.data; e_fm = fm;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_result = '0;
    bus.mult_select = 0; bus.mult_rd = '0; bus.mult_ready = 0; bus.mult_result = '0;

    //   rst av ard ares     ms mrd mr mres      ev erd edat     fm ep prd st er cnt
    row(1, 0, 0, 0,        0, 0,  0, 0,        0, 0,  0,       0, 0, 0,  0, 0, 0); // 0 reset
    row(0, 0, 0, 0,        1, 5,  0, 0,        0, 0,  0,       0, 1, 5,  0, 0, 0); // 1 select rd5
    row(0, 0, 0, 0,        0, 0,  0, 0,        0, 0,  0,       0, 1, 5,  0, 0, 0);
    row(0, 0, 0, 0,        0, 0,  0, 0,        0, 0,  0,       0, 1, 5,  0, 0, 0);
    row(0, 1, 3, 9,        0, 0,  1, 42,       1, 5,  42,      1, 0, 0,  0, 0, 1); // 4 collision
    row(0, 0, 0, 0,        0, 0,  0, 0,        1, 3,  9,       0, 0, 0,  0, 0, 0);
    row(0, 1, 0, 'hffff,   0, 0,  0, 0,        0, 0,  0,       0, 0, 0,  0, 0, 0); // 6 x0
    row(0, 1, 7, 'h77,     0, 0,  0, 0,        1, 7,  'h77,    0, 0, 0,  0, 0, 0); // 7 bypass
    row(0, 0, 0, 0,        0, 0,  1, 5,        0, 0,  0,       0, 0, 0,  0, 1, 0); // 8 stray
    row(0, 0, 0, 0,        0, 0,  0, 0,        0, 0,  0,       0, 0, 0,  0, 1, 0); // 9 sticky
    row(1, 0, 0, 0,        0, 0,  0, 0,        0, 0,  0,       0, 0, 0,  0, 0, 0); // 10
    row(0, 0, 0, 0,        1, 9,  0, 0,        0, 0,  0,       0, 1, 9,  0, 0, 0); // 11
    row(0, 0, 0, 0,        0, 0,  0, 0,        0, 0,  0,       0, 1, 9,  0, 0, 0);
    row(0, 0, 0, 0,        0, 0,  1, 8,        0, 0,  0,       0, 1, 9,  0, 1, 0); // 13 early
    row(0, 0, 0, 0,        0, 0,  0, 0,        0, 0,  0,       0, 0, 0,  0, 1, 0); // 14 timeout
    row(1, 0, 0, 0,        0, 0,  0, 0,        0, 0,  0,       0, 0, 0,  0, 0, 0); // 15
    row(0, 0, 0, 0,        1, 4,  0, 0,        0, 0,  0,       0, 1, 4,  0, 0, 0); // 16
    row(0, 0, 0, 0,        0, 0,  0, 0,        0, 0,  0,       0, 1, 4,  0, 0, 0);
    row(0, 0, 0, 0,        0, 0,  0, 0,        0, 0,  0,       0, 1, 4,  0, 0, 0);
    row(0, 1, 1, 11,       0, 0,  1, 100,      1, 4,  100,     1, 0, 0,  0, 0, 1); // 19
    row(0, 1, 2, 22,       1, 6,  0, 0,        1, 1,  11,      0, 1, 6,  0, 0, 1);
    row(0, 1, 3, 33,       0, 0,  0, 0,        1, 2,  22,      0, 1, 6,  0, 0, 1);
    row(0, 1, 8, 44,       0, 0,  0, 0,        1, 3,  33,      0, 1, 6,  0, 0, 1);
    row(0, 1, 10, 55,      0, 0,  1, 200,      1, 6,  200,     1, 0, 0,  1, 0, 2); // 23 full
    row(0, 1, 11, 66,      1, 12, 0, 0,        1, 8,  44,      0, 1, 12, 1, 0, 2);
    row(0, 1, 13, 77,      0, 0,  0, 0,        1, 10, 55,      0, 1, 12, 1, 0, 2);
    row(0, 1, 14, 88,      0, 0,  0, 0,        1, 11, 66,      0, 1, 12, 1, 0, 2);
    row(0, 1, 15, 99,      0, 0,  1, 300,      1, 12, 300,     1, 0, 0,  1, 1, 2); // 27 drop
    row(0, 0, 0, 0,        0, 0,  0, 0,        1, 13, 77,      0, 0, 0,  0, 1, 1);
    row(0, 0, 0, 0,        0, 0,  0, 0,        1, 14, 88,      0, 0, 0,  0, 1, 0);
    row(0, 0, 0, 0,        0, 0,  0, 0,        0, 0,  0,       0, 0, 0,  0, 1, 0);
    row(1, 0, 0, 0,        0, 0,  0, 0,        0, 0,  0,       0, 0, 0,  0, 0, 0); // 31
    row(0, 0, 0, 0,        1, 20, 0, 0,        0, 0,  0,       0, 1, 20, 0, 0, 0);
    row(0, 0, 0, 0,        0, 0,  0, 0,        0, 0,  0,       0, 1, 20, 0, 0, 0);
    row(0, 0, 0, 0,        0, 0,  0, 0,        0, 0,  0,       0, 1, 20, 0, 0, 0);
    row(0, 1, 21, 1,       0, 0,  1, 500,      1, 20, 500,     1, 0, 0,  0, 0, 1); // 35
    row(0, 1, 22, 2,       1, 23, 0, 0,        1, 21, 1,       0, 1, 23, 0, 0, 1);
    row(0, 1, 24, 3,       0, 0,  0, 0,        1, 22, 2,       0, 1, 23, 0, 0, 1);
    row(1, 1, 25, 4,       0, 0,  0, 0,        0, 0,  0,       0, 0, 0,  0, 0, 0); // 38 reset mid-op
    row(0, 0, 0, 0,        0, 0,  0, 0,        0, 0,  0,       0, 0, 0,  0, 0, 0);
    row(0, 0, 0, 0,        0, 0,  1, 9,        0, 0,  0,       0, 0, 0,  0, 1, 0); // 40 stray
    row(1, 0, 0, 0,        0, 0,  0, 0,        0, 0,  0,       0, 0, 0,  0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      v = vq[i];
      drive(v.rst, v.av, v.ard, v.ares, v.ms, v.mrd, v.mr, v.mres);
      chk($sformatf("vec%0d wb_valid", i), bus.wb_valid, v.ev);
      if (v.ev || v.rst) begin
        chk($sformatf("vec%0d wb_rd", i), bus.wb_rd, v.erd);
        chk($sformatf("vec%0d wb_data", i), bus.wb_data, v.edat);
        chk($sformatf("vec%0d wb_from_mult", i), bus.wb_from_mult, v.efm);
      end
      chk($sformatf("vec%0d mult_pending", i), bus.mult_pending, v.ep);
      if (v.ep || v.rst) chk($sformatf("vec%0d pending_rd", i), bus.pending_rd, v.eprd);
      chk($sformatf("vec%0d alu_stall", i), bus.alu_stall, v.est);
      chk($sformatf("vec%0d protocol_error", i), bus.protocol_error, v.eerr);
      chk($sformatf("vec%0d fifo_count", i), dut.fifo_count, v.ecnt);
    end

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      bit          rst, av, ms, mr;
      logic [4:0]  ard, mrd;
      logic [31:0] ares, mres;
      rst  = (c == 0) || ($urandom_range(0, 199) == 0);
      av   = ($urandom_range(0, 99) < 60);
      ard  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ares = $urandom;
      ms   = ($urandom_range(0, 2) == 0);
      mrd  = 5'($urandom_range(0, 31));
      if (m_pend && m_age == LAT) mr = ($urandom_range(0, 9) != 0);
      else                         mr = ($urandom_range(0, 49) == 0);
      mres = $urandom;
      model_step(rst, av, ard, ares, ms, mrd, mr, mres);
      drive(rst, av, ard, ares, ms, mrd, mr, mres);
      chk($sformatf("rnd%0d wb_valid", c), bus.wb_valid, e_v);
      if (e_v) begin
        chk($sformatf("rnd%0d wb_rd", c), bus.wb_rd, e_rd);
        chk($sformatf("rnd%0d wb_data", c), bus.wb_data, e_dat);
        chk($sformatf("rnd%0d wb_from_mult", c), bus.wb_from_mult, e_fm);
      end
      chk($sformatf("rnd%0d mult_pending", c), bus.mult_pending, m_pend);
      if (m_pend) chk($sformatf("rnd%0d pending_rd", c), bus.pending_rd, m_prd);
      chk($sformatf("rnd%0d alu_stall", c), bus.alu_stall, (q.size() == 2));
      chk($sformatf("rnd%0d protocol_error", c), bus.protocol_error, m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_writeback.md
# exec_writeback

Execute-stage writeback merger that sits directly downstream of the ALU and the 3-cycle multiplier unit. It tracks the destination register of the single in-flight multiply, merges multiply and ALU results onto one register-file write port, and buffers ALU results that collide with a multiply completion in a 2-entry FIFO. It exposes the pending multiply destination to the hazard unit for interlock and forwarding decisions.

## Interface
- DATA_WIDTH, 32, result and write-data width
- REG_SEL, 5, register index width
- MULT_LATENCY, 3, cycles from a sampled multiply select to the multiplier's ready pulse
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- alu_valid  in  1  ALU result valid this cycle
- alu_rd  in  REG_SEL  ALU destination register
- alu_result  in  DATA_WIDTH  ALU result
- mult_select  in  1  same signal driven to the multiplier's select input
- mult_rd  in  REG_SEL  multiply destination, sampled with mult_select
- mult_ready  in  1  multiplier ready pulse
- mult_result  in  DATA_WIDTH  multiplier result, valid with mult_ready
- wb_valid  out  1  register-file write enable
- wb_rd  out  REG_SEL  write index
- wb_data  out  DATA_WIDTH  write data
- wb_from_mult  out  1  current write came from the multiplier
- mult_pending  out  1  a multiply tag is in flight
- pending_rd  out  REG_SEL  destination of the in-flight multiply
- alu_stall  out  1  ALU FIFO full; issue must hold ALU ops
- protocol_error  out  1  sticky error flag, cleared only by reset

## Operation
- Tag capture: mult_select high while mult_pending is low loads pending_rd and starts a counter at 1. The counter increments each cycle. mult_select while pending is ignored, because the multiplier ignores it too.
- Completion: mult_ready high with mult_pending set and counter == MULT_LATENCY consumes {pending_rd, mult_result} and clears pending.
- mult_ready under any other condition is ignored and sets protocol_error.
- The counter reaching MULT_LATENCY without mult_ready clears pending and sets protocol_error.
- Arbitration, one write per cycle, in this priority order:
  - multiply completion first;
  - then FIFO head;
  - then the incoming ALU result as a direct bypass, only when the FIFO is empty.
- An ALU result that does not win arbitration is pushed to the FIFO. ALU results are written back in program order.
- A push and a pop in the same cycle are both allowed. The count does not change.
- alu_valid while the FIFO is full and no slot frees this cycle drops the result and sets protocol_error.
- rd == 0: the selected entry is consumed, but wb_valid stays low.
- FIFO: 2 entries, binary read and write pointers with wrap-around, 2-bit count.
- alu_stall = (count == 2).

## Timing
- wb_valid, wb_rd, wb_data and wb_from_mult are registered. A write appears exactly 1 cycle after the winning input is sampled.
- Multiply path: mult_select sampled at edge N; mult_ready high in cycle N+3; wb_valid high in cycle N+4. Total select-to-write latency is 4 cycles.
- mult_pending rises in cycle N+1 and falls in cycle N+4, the same edge that registers the write.
- A colliding ALU result is written no earlier than 1 cycle after the multiply write.
- Worst-case ALU delay is 2 cycles per buffered entry.
- Reset values:
  - all outputs 0;
  - FIFO empty, pointers 0, counter 0, pending cleared.
- Reset mid-multiply discards the tag. A later stray mult_ready is then handled by the ignore-and-flag rule.

## Structure
- Shared package `exec_pkg`:
  - an `wb_entry_t` struct holding rd and data;
  - the MULT_LATENCY constant, shared with the multiplier instance.
- One sub-module: `wb_fifo`, a parameterised depth-2 synchronous FIFO with push, pop, full, empty and count.
- Tag tracking and arbitration live in the top level.

## Test plan
- **Multiply only:** mult_select with rd=5 at edge 0, mult_ready at cycle 3 with 6×7 → wb_valid at cycle 4, rd=5, data=42, wb_from_mult=1; mult_pending high cycles 1–3.
- **Collision:**
  - Stimulus: ALU rd=3, data=9 in the same cycle as mult_ready (rd=5, data=42).
  - Expected: rd=5 written first, then rd=3 the next cycle; FIFO count peaks at 1.
- **FIFO fill and stall:**
  - Stimulus: two ALU results collide with back-to-back completions.
  - Expected: alu_stall=1 at count 2.
  - Stimulus: a third alu_valid while full.
  - Expected: the result is dropped and protocol_error=1.
- **x0 suppression:** ALU rd=0, data=0xFFFF → no wb_valid; FIFO unaffected.
- **Stray or early ready:** mult_ready with no pending tag, or with counter=2 → no write; protocol_error=1 and held until reset.
- **Reset mid-op:**
  - Stimulus: assert reset in cycle 2 of a multiply with one FIFO entry held.
  - Expected: in the next cycle all outputs are 0 and count=0; no write is issued for either lost result.
